rvsteel_uart_tx_fifo: RTL and testbench

- Transmit buffer that sits directly upstream of the UART and masters its IO interface.
- The CPU pushes bytes at bus speed into a FIFO on the block's slave port.
- A drain state machine polls the UART TX-ready register at 0x80000000. When ready, it writes the head byte to 0x80000000, one byte per UART frame.
- Removes CPU busy-wait on serial output.

---
 rtl/rvsteel_uart_tx_fifo_if.sv | 18 +
 rtl/rvsteel_uart_tx_fifo.sv | 113 +++++++++++
 tb/tb_rvsteel_uart_tx_fifo.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvsteel_uart_tx_fifo_if.sv
// rvsteel_uart_tx_fifo_if: RISC-V Steel IO bus bundle with master and slave views
interface rvsteel_uart_tx_fifo_if;
    logic [31:0] rw_address;
    logic [31:0] read_data;
    logic        read_request;
    logic        read_response;
    logic [7:0]  write_data;
    logic        write_request;
    logic        write_response;
    modport master (
        output rw_address, read_request, write_data, write_request,
        input  read_data, read_response, write_response
    );
    modport slave (
        input  rw_address, read_request, write_data, write_request,
        output read_data, read_response, write_response
    );
endinterface

// File: rtl/rvsteel_uart_tx_fifo.sv
// rvsteel_uart_tx_fifo: byte FIFO on the CPU bus that drains itself into the UART, one byte per ready poll
module rvsteel_uart_tx_fifo #(
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] BASE_ADDRESS = 32'h80000100,
    parameter logic [31:0] UART_ADDRESS = 32'h80000000
) (
    input  logic                          clock,
    input  logic                          reset,
    rvsteel_uart_tx_fifo_if.slave         bus,
    rvsteel_uart_tx_fifo_if.master        uart,
    output logic                          fifo_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, POLL, POLL_WAIT, WRITE, WRITE_WAIT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          read_response_q, write_response_q;
    logic          uart_read_request_q, uart_read_request_d;
    logic          uart_write_request_q, uart_write_request_d;
    logic          full, push_hit, push, pop, level_read, status_read;
    logic          unused_read_data;

    assign full        = level_q == LW'(FIFO_DEPTH);
    assign fifo_empty  = level_q == '0;
    assign push_hit    = bus.write_request && bus.rw_address == BASE_ADDRESS;
    assign push        = push_hit && !full;
    assign level_read  = bus.read_request && bus.rw_address == BASE_ADDRESS;
    assign status_read = bus.read_request && bus.rw_address == BASE_ADDRESS + 32'd4;

    // Pointer/level bookkeeping, sticky overflow (a new drop beats the read-clear) and slave read mux
    always_comb begin
        head_d      = pop ? head_q + AW'(1) : head_q;
        tail_d      = push ? tail_q + AW'(1) : tail_q;
        level_d     = level_q + LW'(push) - LW'(pop);
        overflow_d  = (push_hit && full) || (overflow_q && !status_read);
        read_data_d = level_read ? 32'(level_q) :
                      status_read ? {29'b0, overflow_q, full, fifo_empty} : '0;
    end

    // Drain sequencer: poll ready, write head byte only after a ready poll, pop on write response
    always_comb begin
        state_d              = state_q;
        uart_read_request_d  = 1'b0;
        uart_write_request_d = 1'b0;
        pop                  = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                state_d             = POLL;
                uart_read_request_d = 1'b1;
            end
            POLL: state_d = POLL_WAIT;
            POLL_WAIT: if (uart.read_response) begin
                state_d              = uart.read_data[0] ? WRITE : POLL;
                uart_write_request_d = uart.read_data[0];
                uart_read_request_d  = !uart.read_data[0];
            end
            WRITE: state_d = WRITE_WAIT;
            WRITE_WAIT: if (uart.write_response) begin
                state_d = IDLE;
                pop     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // All control state and registered outputs, cleared by the active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q              <= IDLE;
            head_q               <= '0;
            tail_q               <= '0;
            level_q              <= '0;
            overflow_q           <= 1'b0;
            read_data_q          <= '0;
            read_response_q      <= 1'b0;
            write_response_q     <= 1'b0;
            uart_read_request_q  <= 1'b0;
            uart_write_request_q <= 1'b0;
        end else begin
            state_q              <= state_d;
            head_q               <= head_d;
            tail_q               <= tail_d;
            level_q              <= level_d;
            overflow_q           <= overflow_d;
            read_data_q          <= read_data_d;
            read_response_q      <= bus.read_request;
            write_response_q     <= bus.write_request;
            uart_read_request_q  <= uart_read_request_d;
            uart_write_request_q <= uart_write_request_d;
        end
    end

    // Storage needs no reset: entries are only read between a push and its pop
    always_ff @(posedge clock) begin
        if (push) mem_q[tail_q] <= bus.write_data;
    end

    assign bus.read_data       = read_data_q;
    assign bus.read_response   = read_response_q;
    assign bus.write_response  = write_response_q;
    assign uart.read_request   = uart_read_request_q;
    assign uart.write_request  = uart_write_request_q;
    assign uart.rw_address     = (uart_read_request_q || uart_write_request_q) ? UART_ADDRESS : '0;
    assign uart.write_data     = uart_write_request_q ? mem_q[head_q] : '0;
    assign unused_read_data    = ^uart.read_data[31:1];
endmodule

// File: tb/tb_rvsteel_uart_tx_fifo.sv
// tb_rvsteel_uart_tx_fifo: directed tests of the UART transmit FIFO against a 1-cycle UART model
module tb_rvsteel_uart_tx_fifo;
    localparam logic [31:0] BASE = 32'h80000100;
    localparam logic [31:0] UADR = 32'h80000000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic fifo_empty;
    rvsteel_uart_tx_fifo_if bus();
    rvsteel_uart_tx_fifo_if uart();

    int tests = 0;
    int fails = 0;
    int busy = 0;
    int busy_cycles = 0;
    int bad_writes = 0;
    bit hold = 1'b0;
    bit last_ready = 1'b0;
    logic [7:0] rx_q[$];

    rvsteel_uart_tx_fifo dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .uart(uart),
        .fifo_empty(fifo_empty)
    );

    always #5 clock = ~clock;

    // UART model: 1-cycle responses, bit0 ready unless held or busy after a byte
    always @(posedge clock) begin
        uart.read_response  <= uart.read_request;
        uart.write_response <= uart.write_request;
        uart.read_data      <= {31'b0, uart.read_request && busy == 0 && !hold};
        if (uart.read_request) last_ready <= busy == 0 && !hold;
        if (uart.write_request) begin
            rx_q.push_back(uart.write_data);
            if (!last_ready) bad_writes <= bad_writes + 1;
            last_ready <= 1'b0;
            busy <= busy_cycles;
        end else if (busy != 0) begin
            busy <= busy - 1;
        end
    end

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic r);
        @(negedge clock);
        bus.rw_address = a;
        bus.read_request = 1'b1;
        @(negedge clock);
        bus.read_request = 1'b0;
        bus.rw_address = '0;
        d = bus.read_data;
        r = bus.read_response;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] b);
        @(negedge clock);
        bus.rw_address = a;
        bus.write_data = b;
        bus.write_request = 1'b1;
        @(negedge clock);
        bus.write_request = 1'b0;
        bus.rw_address = '0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic r;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        tests++;
        if ({uart.read_request, uart.write_request, bus.read_response, bus.write_response} !== 4'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b expected 0000", {uart.read_request, uart.write_request, bus.read_response, bus.write_response});
        end
        tests++;
        if ({uart.rw_address, uart.write_data, bus.read_data} !== 72'h0) begin
            fails++;
            $display("FAIL reset_data: uaddr=%h wdata=%h rdata=%h expected 0", uart.rw_address, uart.write_data, bus.read_data);
        end
        tests++;
        if (fifo_empty !== 1'b1) begin
            fails++;
            $display("FAIL reset_empty: got %b expected 1", fifo_empty);
        end
        reset = 1'b1;
        rd(BASE, d, r);
        tests++;
        if ({r, d} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL reset_level: resp=%b data=%h expected 1/0", r, d);
        end
    endtask

    task automatic test_single;
        @(negedge clock);
        bus.rw_address = BASE;
        bus.write_data = 8'h55;
        bus.write_request = 1'b1;
        @(negedge clock);
        bus.write_request = 1'b0;
        tests++;
        if ({bus.write_response, uart.read_request} !== 2'b10) begin
            fails++;
            $display("FAIL single_push: wresp/poll=%b expected 10", {bus.write_response, uart.read_request});
        end
        @(negedge clock);
        tests++;
        if (uart.read_request !== 1'b1 || uart.rw_address !== UADR) begin
            fails++;
            $display("FAIL single_poll: req=%b addr=%h expected 1/%h", uart.read_request, uart.rw_address, UADR);
        end
        @(negedge clock);
        tests++;
        if ({uart.read_request, uart.write_request} !== 2'b00) begin
            fails++;
            $display("FAIL single_wait: strobes=%b expected 00", {uart.read_request, uart.write_request});
        end
        @(negedge clock);
        tests++;
        if (uart.write_request !== 1'b1 || uart.write_data !== 8'h55 || uart.rw_address !== UADR) begin
            fails++;
            $display("FAIL single_write: req=%b data=%h addr=%h expected 1/55/%h", uart.write_request, uart.write_data, uart.rw_address, UADR);
        end
        @(negedge clock);
        tests++;
        if ({uart.write_request, fifo_empty} !== 2'b00) begin
            fails++;
            $display("FAIL single_before_pop: req/empty=%b expected 00", {uart.write_request, fifo_empty});
        end
        @(negedge clock);
        tests++;
        if (fifo_empty !== 1'b1) begin
            fails++;
            $display("FAIL single_after_pop: empty=%b expected 1", fifo_empty);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [3] = '{8'h41, 8'h42, 8'h43};
        int n0 = rx_q.size();
        busy_cycles = 50;
        @(negedge clock);
        bus.rw_address = BASE;
        bus.write_request = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.write_data = exp_b[i];
            @(negedge clock);
        end
        bus.write_request = 1'b0;
        bus.read_request = 1'b1;
        @(negedge clock);
        bus.read_request = 1'b0;
        bus.rw_address = '0;
        tests++;
        if (bus.read_data !== 32'd3) begin
            fails++;
            $display("FAIL b2b_level: got %0d expected 3", bus.read_data);
        end
        for (int i = 0; i < 1000 && rx_q.size() < n0 + 3; i++) @(negedge clock);
        tests++;
        if (rx_q.size() !== n0 + 3) begin
            fails++;
            $display("FAIL b2b_count: got %0d bytes expected %0d", rx_q.size() - n0, 3);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (rx_q[n0 + i] !== exp_b[i]) begin
                    fails++;
                    $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[n0 + i], exp_b[i]);
                end
            end
        end
        for (int i = 0; i < 20 && !fifo_empty; i++) @(negedge clock);
        tests++;
        if (bad_writes !== 0) begin
            fails++;
            $display("FAIL b2b_write_while_busy: got %0d expected 0", bad_writes);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        logic r;
        int n0 = rx_q.size();
        hold = 1'b1;
        busy_cycles = 2;
        @(negedge clock);
        bus.rw_address = BASE;
        bus.write_request = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.write_data = 8'(8'h60 + i);
            @(negedge clock);
        end
        bus.write_request = 1'b0;
        rd(BASE, d, r);
        tests++;
        if (d !== 32'd16) begin
            fails++;
            $display("FAIL ovf_level: got %0d expected 16", d);
        end
        rd(BASE + 32'd4, d, r);
        tests++;
        if (d !== 32'h6) begin
            fails++;
            $display("FAIL ovf_status1: got %h expected 6", d);
        end
        rd(BASE + 32'd4, d, r);
        tests++;
        if (d !== 32'h2) begin
            fails++;
            $display("FAIL ovf_status2: got %h expected 2", d);
        end
        tests++;
        if (rx_q.size() !== n0) begin
            fails++;
            $display("FAIL ovf_held: got %0d bytes expected 0", rx_q.size() - n0);
        end
        hold = 1'b0;
        for (int i = 0; i < 2000 && rx_q.size() < n0 + 16; i++) @(negedge clock);
        repeat (60) @(negedge clock);
        tests++;
        if (rx_q.size() !== n0 + 16 || fifo_empty !== 1'b1) begin
            fails++;
            $display("FAIL ovf_count: got %0d bytes empty=%b expected 16/1", rx_q.size() - n0, fifo_empty);
        end else begin
            for (int i = 0; i < 16; i++) begin
                tests++;
                if (rx_q[n0 + i] !== 8'(8'h60 + i)) begin
                    fails++;
                    $display("FAIL ovf_byte%0d: got %h expected %h", i, rx_q[n0 + i], 8'(8'h60 + i));
                end
            end
        end
    endtask

    task automatic test_push_pop;
        int n0 = rx_q.size();
        busy_cycles = 0;
        @(negedge clock);
        bus.rw_address = BASE;
        bus.write_data = 8'h11;
        bus.write_request = 1'b1;
        @(negedge clock);
        bus.write_request = 1'b0;
        repeat (4) @(negedge clock);
        tests++;
        if (uart.write_response !== 1'b1) begin
            fails++;
            $display("FAIL pp_pop_cycle: uart wresp=%b expected 1", uart.write_response);
        end
        bus.write_data = 8'h22;
        bus.write_request = 1'b1;
        @(negedge clock);
        bus.write_request = 1'b0;
        bus.read_request = 1'b1;
        tests++;
        if (fifo_empty !== 1'b0) begin
            fails++;
            $display("FAIL pp_empty: got %b expected 0", fifo_empty);
        end
        @(negedge clock);
        bus.read_request = 1'b0;
        bus.rw_address = '0;
        tests++;
        if (bus.read_data !== 32'd1) begin
            fails++;
            $display("FAIL pp_level: got %0d expected 1", bus.read_data);
        end
        for (int i = 0; i < 100 && rx_q.size() < n0 + 2; i++) @(negedge clock);
        tests++;
        if (rx_q.size() !== n0 + 2) begin
            fails++;
            $display("FAIL pp_count: got %0d bytes expected 2", rx_q.size() - n0);
        end else begin
            tests++;
            if ({rx_q[n0], rx_q[n0 + 1]} !== 16'h1122) begin
                fails++;
                $display("FAIL pp_order: got %h%h expected 1122", rx_q[n0], rx_q[n0 + 1]);
            end
        end
        for (int i = 0; i < 20 && !fifo_empty; i++) @(negedge clock);
    endtask

    task automatic test_reset_midflight;
        logic [31:0] d;
        logic r;
        int n0 = rx_q.size();
        hold = 1'b1;
        wr(BASE, 8'h77);
        for (int i = 0; i < 20 && uart.read_request !== 1'b1; i++) @(negedge clock);
        tests++;
        if (uart.read_request !== 1'b1) begin
            fails++;
            $display("FAIL rst_poll_seen: got %b expected 1", uart.read_request);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if ({uart.read_request, uart.write_request} !== 2'b00 || uart.rw_address !== 32'h0) begin
            fails++;
            $display("FAIL rst_pollwait_strobes: %b addr=%h expected 00/0", {uart.read_request, uart.write_request}, uart.rw_address);
        end
        reset = 1'b1;
        rd(BASE, d, r);
        tests++;
        if (d !== 32'd0 || fifo_empty !== 1'b1) begin
            fails++;
            $display("FAIL rst_pollwait_level: got %0d empty=%b expected 0/1", d, fifo_empty);
        end
        hold = 1'b0;
        repeat (40) @(negedge clock);
        tests++;
        if (rx_q.size() !== n0) begin
            fails++;
            $display("FAIL rst_pollwait_nowrite: got %0d bytes expected 0", rx_q.size() - n0);
        end
        wr(BASE, 8'h88);
        wr(BASE, 8'h99);
        for (int i = 0; i < 20 && uart.write_request !== 1'b1; i++) @(negedge clock);
        tests++;
        if (uart.write_request !== 1'b1 || uart.write_data !== 8'h88) begin
            fails++;
            $display("FAIL rst_write_seen: req=%b data=%h expected 1/88", uart.write_request, uart.write_data);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if ({uart.read_request, uart.write_request} !== 2'b00 || uart.rw_address !== 32'h0) begin
            fails++;
            $display("FAIL rst_writewait_strobes: %b addr=%h expected 00/0", {uart.read_request, uart.write_request}, uart.rw_address);
        end
        reset = 1'b1;
        rd(BASE, d, r);
        tests++;
        if (d !== 32'd0) begin
            fails++;
            $display("FAIL rst_writewait_level: got %0d expected 0", d);
        end
        repeat (40) @(negedge clock);
        tests++;
        if (rx_q.size() !== n0 + 1) begin
            fails++;
            $display("FAIL rst_writewait_nowrite: got %0d bytes expected 1", rx_q.size() - n0);
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] d;
        logic r;
        rd(32'h00001234, d, r);
        tests++;
        if ({r, d} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL unmapped_read: resp=%b data=%h expected 1/0", r, d);
        end
        rd(BASE + 32'd8, d, r);
        tests++;
        if ({r, d} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL base8_read: resp=%b data=%h expected 1/0", r, d);
        end
        wr(BASE + 32'd4, 8'hAA);
        rd(BASE, d, r);
        tests++;
        if (d !== 32'd0) begin
            fails++;
            $display("FAIL unmapped_write_level: got %0d expected 0", d);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rw_address = '0;
        bus.read_request = 1'b0;
        bus.write_request = 1'b0;
        bus.write_data = '0;
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_push_pop;
        test_reset_midflight;
        test_unmapped;
        tests++;
        if (bad_writes !== 0) begin
            fails++;
            $display("FAIL write_without_ready: got %0d expected 0", bad_writes);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
